// File: rtl/sipo_frame_receiver.sv
// ---------------------------------------------------------------------------
// sipo_frame_receiver
//
// Serial-in / parallel-out receiver for a single-bit shift-register link.
// One serial bit is sampled per rising clk edge. A frame is a start bit (1),
// WIDTH data bits sent LSB first, then a stop bit (0). Each good word is
// presented on a valid/ready holding register. A bad stop bit produces a
// frame_err pulse. A good frame that arrives while the holding register is
// still full produces an overrun pulse.
//
// Ports
//   clk        in   1      rising-edge clock, one serial bit per cycle
//   rst        in   1      asynchronous active-low reset, released synchronously
//   serial_in  in   1      serial line, idles low
//   out_data   out  WIDTH  received word, stable while out_valid=1
//   out_valid  out  1      out_data holds an unconsumed word
//   out_ready  in   1      word consumed when out_valid && out_ready at an edge
//   busy       out  1      high while a frame is in progress (DATA or STOP)
//   frame_err  out  1      one-cycle pulse: stop bit sampled as 1
//   overrun    out  1      one-cycle pulse: good frame dropped, register full
// ---------------------------------------------------------------------------
module sipo_frame_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state_reg,     state_next;
    logic [CW-1:0]    count_reg,     count_next;
    logic [WIDTH-1:0] shift_reg,     shift_next;
    logic [WIDTH-1:0] out_data_reg,  out_data_next;
    logic             out_valid_reg, out_valid_next;
    logic             frame_err_reg, frame_err_next;
    logic             overrun_reg,   overrun_next;
    logic             good_frame;

    // Each data bit lands directly in its own position, selected by the bit
    // counter, so no final shift or reversal is needed at the stop bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift_bit
            assign shift_next[gi] = (state_reg == S_DATA && count_reg == CW'(gi))
                                    ? serial_in : shift_reg[gi];
        end
    endgenerate

    // Next-state, counter and holding-register logic.
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;
        good_frame     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (serial_in) begin
                    state_next = S_DATA;
                    count_next = '0;
                end
            end
            S_DATA: begin
                if (count_reg == LAST_BIT) begin
                    state_next = S_STOP;
                    count_next = '0;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            S_STOP: begin
                // A 1 here is a framing error, not a new start bit: always
                // return to IDLE and wait for a fresh start bit.
                state_next = S_IDLE;
                if (serial_in) begin
                    frame_err_next = 1'b1;
                end else begin
                    good_frame = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                count_next = '0;
            end
        endcase

        if (good_frame) begin
            // Register empty, or the held word is consumed on this very edge.
            if (!out_valid_reg || out_ready) begin
                out_data_next  = shift_reg;
                out_valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            count_reg     <= '0;
            shift_reg     <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            shift_reg     <= shift_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    // Decoded straight from the state register so an asynchronous reset
    // drops busy immediately.
    assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_sipo_frame_receiver
//
// Directed bench for sipo_frame_receiver (WIDTH=8). Inputs change 1 ns after
// a rising edge and outputs are sampled at that same point, so every sample
// shows the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_sipo_frame_receiver;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             serial_in;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    int checks;
    int errors;

    sipo_frame_receiver #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, then the given stop bit.
    // Returns one tick after the stop edge has been taken.
    task automatic send_frame(input logic [WIDTH-1:0] data, input logic stop_bit);
        serial_in = 1'b1;
        tick();
        for (int i = 0; i < WIDTH; i++) begin
            serial_in = data[i];
            tick();
        end
        serial_in = stop_bit;
        tick();
        serial_in = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        out_ready = 1'b0;
        serial_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            serial_in = ~serial_in;
            tick();
        end
        checks++;
        if ({out_valid, busy, frame_err, overrun} !== 4'b0000 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b busy=%b ferr=%b ovr=%b data=%h, want all 0",
                     out_valid, busy, frame_err, overrun, out_data);
        end
        serial_in = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b valid=%b, want 0 0", busy, out_valid);
        end
        $display("test_reset: done");
    endtask

    task automatic test_good_frame();
        logic [9:0] bits;
        logic       early_valid;
        bits        = 10'b0101001011; // send order bit0 first: 1,1,0,1,0,0,1,0,1,0
        early_valid = 1'b0;
        out_ready   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            serial_in = bits[i];
            tick();
            if (i < 9 && out_valid !== 1'b0) early_valid = 1'b1;
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL good_busy_after_start: got %b want 1", busy);
                end
            end
        end
        serial_in = 1'b0;
        checks++;
        if (early_valid) begin
            errors++;
            $display("FAIL good_latency: out_valid rose before edge 10, want only after stop edge");
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL good_word: got valid=%b data=%h busy=%b, want 1 a5 0",
                     out_valid, out_data, busy);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
            errors++;
            $display("FAIL good_consumed: got valid=%b data=%h, want 0 a5", out_valid, out_data);
        end
        $display("test_good_frame: word a5");
    endtask

    task automatic test_frame_error();
        out_ready = 1'b1;
        send_frame(8'h3C, 1'b1);
        checks++;
        if (frame_err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_pulse: got ferr=%b valid=%b busy=%b, want 1 0 0",
                     frame_err, out_valid, busy);
        end
        tick();
        checks++;
        if (frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_one_cycle: got ferr=%b busy=%b, want 0 0", frame_err, busy);
        end
        send_frame(8'h3C, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL ferr_recover: got valid=%b data=%h ferr=%b, want 1 3c 0",
                     out_valid, out_data, frame_err);
        end
        tick();
        $display("test_frame_error: error then word 3c");
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: got valid=%b data=%h ovr=%b, want 1 11 0",
                     out_valid, out_data, overrun);
        end
        send_frame(8'h22, 1'b0);
        checks++;
        if (overrun !== 1'b1 || out_data !== 8'h11 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_pulse: got ovr=%b data=%h valid=%b, want 1 11 1",
                     overrun, out_data, out_valid);
        end
        tick();
        checks++;
        if (overrun !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_one_cycle: got ovr=%b valid=%b, want 0 1", overrun, out_valid);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL ovr_drain: got valid=%b data=%h, want 0 11", out_valid, out_data);
        end
        out_ready = 1'b0;
        $display("test_overrun: held 11, dropped 22");
    endtask

    task automatic test_simultaneous();
        logic [WIDTH-1:0] w;
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0);
        w = 8'h22;
        serial_in = 1'b1;
        tick();
        for (int i = 0; i < WIDTH; i++) begin
            serial_in = w[i];
            tick();
        end
        serial_in = 1'b0;
        out_ready = 1'b1;            // consume 11 on the same edge 22 completes
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h22 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL simul_swap: got valid=%b data=%h ovr=%b, want 1 22 0",
                     out_valid, out_data, overrun);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain: got valid=%b want 0", out_valid);
        end
        out_ready = 1'b0;
        $display("test_simultaneous: 11 replaced by 22");
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send_frame(8'h5A, 1'b0);
        serial_in = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            serial_in = 1'b1;
            tick();
        end
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got busy=%b valid=%b, want 1 1", busy, out_valid);
        end
        #3;
        rst = 1'b0;                  // between clock edges
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: got busy=%b valid=%b data=%h ferr=%b, want 0 0 00 0",
                     busy, out_valid, out_data, frame_err);
        end
        serial_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL areset_release: got busy=%b ferr=%b, want 0 0", busy, frame_err);
        end
        out_ready = 1'b1;
        send_frame(8'hFF, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL areset_next_frame: got valid=%b data=%h ferr=%b, want 1 ff 0",
                     out_valid, out_data, frame_err);
        end
        tick();
        $display("test_async_reset: abort then word ff");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        serial_in = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_good_frame();
        test_frame_error();
        test_overrun();
        test_simultaneous();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
